// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: tracks fetched instructions from BHT read-out until execute
// resolves them, generates the BHT update fields, flushes wrong-path entries on a
// mispredict and keeps saturating branch / mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned LOWER = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             fetch_valid,
    input  logic [LOWER-1:0] fetch_pc,
    output logic             fetch_ready,
    output logic [LOWER-1:0] bht_read_addr,
    input  logic             prediction,
    input  logic             resolve_valid,
    input  logic             resolve_branch,
    input  logic             resolve_taken,
    input  logic             resolve_jump,
    output logic [LOWER-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             bht_jumped,
    output logic             bht_branch,
    output logic             mispredict,
    output logic             queue_empty,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [CntW:0]    DepthC  = (CntW + 1)'(DEPTH);
    localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [CNT_W-1:0] PerfOne = CNT_W'(1);

    // Queue storage and control state
    logic [LOWER-1:0] pc_mem_q [DEPTH];
    logic [DEPTH-1:0] pred_mem_q;
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;

    // Fetch waiting one cycle for its registered BHT prediction
    logic             p_valid_q, p_valid_d;
    logic [LOWER-1:0] p_pc_q, p_pc_d;

    // Registered BHT update / status outputs
    logic [LOWER-1:0] write_addr_q, write_addr_d;
    logic             was_taken_q, was_taken_d;
    logic             jumped_q, jumped_d;
    logic             branch_q, branch_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [CntW:0]    occupancy;
    logic             accept;
    logic             push;
    logic             pop;
    logic             flush;
    logic [LOWER-1:0] head_pc;
    logic             head_pred;

    // The in-flight capture counts against capacity so a full queue never overflows.
    assign occupancy     = {1'b0, count_q} + {{CntW{1'b0}}, p_valid_q};
    assign fetch_ready   = occupancy < DepthC;
    assign bht_read_addr = fetch_pc;

    assign accept    = en & fetch_valid & fetch_ready;
    assign push      = en & p_valid_q;
    assign pop       = en & resolve_valid & (count_q != '0);
    assign head_pc   = pc_mem_q[head_q];
    assign head_pred = pred_mem_q[head_q];
    // A conditional branch whose outcome disagrees with its prediction kills all younger work.
    assign flush     = pop & resolve_branch & (resolve_taken != head_pred);

    assign queue_empty = (count_q == '0) & ~p_valid_q;

    // Next-state for pointers, occupancy and the pending capture
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        p_valid_d = p_valid_q;
        p_pc_d    = p_pc_q;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            p_valid_d = 1'b0;
        end else begin
            if (pop) begin
                head_d = head_q + PtrOne;
            end
            if (push) begin
                tail_d = tail_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
            if (accept) begin
                p_valid_d = 1'b1;
                p_pc_d    = fetch_pc;
            end else if (push) begin
                p_valid_d = 1'b0;
            end
        end
    end

    // Next-state for BHT update fields and saturating performance counters
    always_comb begin
        write_addr_d  = write_addr_q;
        was_taken_d   = was_taken_q;
        jumped_d      = jumped_q;
        branch_d      = branch_q;
        mispredict_d  = mispredict_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (en) begin
            if (pop) begin
                write_addr_d = head_pc;
                was_taken_d  = resolve_branch & resolve_taken;
                jumped_d     = resolve_jump;
                branch_d     = resolve_branch;
                mispredict_d = flush;
                if (resolve_branch && (branch_cnt_q != '1)) begin
                    branch_cnt_d = branch_cnt_q + PerfOne;
                end
                if (flush && (mispred_cnt_q != '1)) begin
                    mispred_cnt_d = mispred_cnt_q + PerfOne;
                end
            end else begin
                // Write address holds; cleared flags make a stray BHT update impossible.
                was_taken_d  = 1'b0;
                jumped_d     = 1'b0;
                branch_d     = 1'b0;
                mispredict_d = 1'b0;
            end
        end
    end

    // Control and output state registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            p_valid_q     <= 1'b0;
            p_pc_q        <= '0;
            write_addr_q  <= '0;
            was_taken_q   <= 1'b0;
            jumped_q      <= 1'b0;
            branch_q      <= 1'b0;
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            p_valid_q     <= p_valid_d;
            p_pc_q        <= p_pc_d;
            write_addr_q  <= write_addr_d;
            was_taken_q   <= was_taken_d;
            jumped_q      <= jumped_d;
            branch_q      <= branch_d;
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry storage: capture {p_pc, prediction} at the tail unless the cycle flushes
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i] <= '0;
            end
            pred_mem_q <= '0;
        end else if (push && !flush) begin
            pc_mem_q[tail_q]   <= p_pc_q;
            pred_mem_q[tail_q] <= prediction;
        end
    end

    assign bht_write_addr   = write_addr_q;
    assign bht_was_taken    = was_taken_q;
    assign bht_jumped       = jumped_q;
    assign bht_branch       = branch_q;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model. A second instance with 4-bit
// counters exercises counter saturation on the same stimulus.
module tb_branch_resolve_queue;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       en;
    logic       fetch_valid;
    logic [4:0] fetch_pc;
    logic       prediction;
    logic       resolve_valid;
    logic       resolve_branch;
    logic       resolve_taken;
    logic       resolve_jump;

    logic        fetch_ready, fetch_ready_s;
    logic [4:0]  bht_read_addr, bht_read_addr_s;
    logic [4:0]  bht_write_addr, bht_write_addr_s;
    logic        bht_was_taken, bht_was_taken_s;
    logic        bht_jumped, bht_jumped_s;
    logic        bht_branch, bht_branch_s;
    logic        mispredict, mispredict_s;
    logic        queue_empty, queue_empty_s;
    logic [15:0] branch_count, mispredict_count;
    logic [3:0]  branch_count_s, mispredict_count_s;

    int total = 0;
    int bad   = 0;

    // Reference model: program-order queue of {pc, prediction} plus pending fetch
    logic [4:0] mq_pc[$];
    bit         mq_pred[$];
    bit         m_pend;
    logic [4:0] m_ppc;
    logic [4:0] m_addr;
    bit         m_was, m_jmp, m_br, m_mis;
    int         m_bc, m_mc;

    always #5 clk = ~clk;

    branch_resolve_queue #(.LOWER(5), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .en               (en),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_ready      (fetch_ready),
        .bht_read_addr    (bht_read_addr),
        .prediction       (prediction),
        .resolve_valid    (resolve_valid),
        .resolve_branch   (resolve_branch),
        .resolve_taken    (resolve_taken),
        .resolve_jump     (resolve_jump),
        .bht_write_addr   (bht_write_addr),
        .bht_was_taken    (bht_was_taken),
        .bht_jumped       (bht_jumped),
        .bht_branch       (bht_branch),
        .mispredict       (mispredict),
        .queue_empty      (queue_empty),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    branch_resolve_queue #(.LOWER(5), .DEPTH(4), .CNT_W(4)) u_sat (
        .clk              (clk),
        .arst_n           (arst_n),
        .en               (en),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_ready      (fetch_ready_s),
        .bht_read_addr    (bht_read_addr_s),
        .prediction       (prediction),
        .resolve_valid    (resolve_valid),
        .resolve_branch   (resolve_branch),
        .resolve_taken    (resolve_taken),
        .resolve_jump     (resolve_jump),
        .bht_write_addr   (bht_write_addr_s),
        .bht_was_taken    (bht_was_taken_s),
        .bht_jumped       (bht_jumped_s),
        .bht_branch       (bht_branch_s),
        .mispredict       (mispredict_s),
        .queue_empty      (queue_empty_s),
        .branch_count     (branch_count_s),
        .mispredict_count (mispredict_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit m_ready();
        return (mq_pc.size() + int'(m_pend)) < 4;
    endfunction

    function automatic bit m_empty();
        return (mq_pc.size() == 0) && !m_pend;
    endfunction

    task automatic model_reset();
        mq_pc.delete();
        mq_pred.delete();
        m_pend = 0;
        m_ppc  = '0;
        m_addr = '0;
        m_was  = 0;
        m_jmp  = 0;
        m_br   = 0;
        m_mis  = 0;
        m_bc   = 0;
        m_mc   = 0;
    endtask

    task automatic check_state();
        check("queue_empty", 32'(queue_empty), 32'(m_empty()));
        check("fetch_ready", 32'(fetch_ready), 32'(m_ready()));
        check("write_addr", 32'(bht_write_addr), 32'(m_addr));
        check("was_taken", 32'(bht_was_taken), 32'(m_was));
        check("jumped", 32'(bht_jumped), 32'(m_jmp));
        check("branch", 32'(bht_branch), 32'(m_br));
        check("mispredict", 32'(mispredict), 32'(m_mis));
        check("branch_count", 32'(branch_count), 32'(m_bc));
        check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
        check("sat_queue_empty", 32'(queue_empty_s), 32'(m_empty()));
        check("sat_write_addr", 32'(bht_write_addr_s), 32'(m_addr));
        check("sat_mispredict", 32'(mispredict_s), 32'(m_mis));
        check("sat_branch_count", 32'(branch_count_s), 32'(sat15(m_bc)));
        check("sat_mispredict_count", 32'(mispredict_count_s), 32'(sat15(m_mc)));
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input bit e, input bit fv, input logic [4:0] fpc, input bit pr,
                        input bit rv, input bit rb, input bit rt, input bit rj);
        bit         acc, psh, pp;
        logic [4:0] hpc;
        bit         hpred;
        en             = e;
        fetch_valid    = fv;
        fetch_pc       = fpc;
        prediction     = pr;
        resolve_valid  = rv;
        resolve_branch = rb;
        resolve_taken  = rt;
        resolve_jump   = rj;
        #1;
        check("pre_fetch_ready", 32'(fetch_ready), 32'(m_ready()));
        check("pre_sat_fetch_ready", 32'(fetch_ready_s), 32'(m_ready()));
        check("read_addr", 32'(bht_read_addr), 32'(fpc));
        acc = e && fv && m_ready();
        psh = e && m_pend;
        pp  = e && rv && (mq_pc.size() != 0);
        if (e) begin
            if (pp) begin
                hpc    = mq_pc.pop_front();
                hpred  = mq_pred.pop_front();
                m_addr = hpc;
                m_was  = rb && rt;
                m_jmp  = rj;
                m_br   = rb;
                m_mis  = rb && (rt != hpred);
                if (rb) m_bc++;
                if (m_mis) m_mc++;
            end else begin
                m_was = 0;
                m_jmp = 0;
                m_br  = 0;
                m_mis = 0;
            end
            if (m_mis) begin
                mq_pc.delete();
                mq_pred.delete();
                m_pend = 0;
            end else begin
                if (psh) begin
                    mq_pc.push_back(m_ppc);
                    mq_pred.push_back(pr);
                end
                if (acc) begin
                    m_pend = 1;
                    m_ppc  = fpc;
                end else if (psh) begin
                    m_pend = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        step(1, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        en            = 0;
        fetch_valid   = 0;
        resolve_valid = 0;
        arst_n        = 0;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        arst_n = 1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        arst_n         = 1;
        en             = 0;
        fetch_valid    = 0;
        fetch_pc       = '0;
        prediction     = 0;
        resolve_valid  = 0;
        resolve_branch = 0;
        resolve_taken  = 0;
        resolve_jump   = 0;
        model_reset();
        #2;
        apply_reset();

        // Correctly predicted taken branch at pc 3
        step(1, 1, 5'd3, 0, 0, 0, 0, 0);
        step(1, 0, 5'd0, 1, 0, 0, 0, 0);
        idle();
        step(1, 0, 5'd0, 0, 1, 1, 1, 0);
        idle();

        // Mispredict at pc 7 with two younger entries queued behind it
        step(1, 1, 5'd7, 0, 0, 0, 0, 0);
        step(1, 1, 5'd8, 0, 0, 0, 0, 0);
        step(1, 1, 5'd9, 1, 0, 0, 0, 0);
        step(1, 0, 5'd0, 1, 0, 0, 0, 0);
        step(1, 1, 5'd10, 0, 1, 1, 1, 0);
        idle();

        // Jump at pc 12, then resolve against an empty queue
        step(1, 1, 5'd12, 0, 0, 0, 0, 0);
        step(1, 0, 5'd0, 1, 0, 0, 0, 0);
        step(1, 0, 5'd0, 0, 1, 0, 0, 1);
        step(1, 0, 5'd0, 0, 1, 1, 1, 0);

        // Fill to capacity across the pointer wrap; fifth fetch is dropped
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 5'(i), 1, 0, 0, 0, 0);
        end
        step(1, 0, 5'd0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 5'd0, 0, 1, 0, 0, 0);
        end

        // Stall for three cycles mid-stream with requests asserted
        step(1, 1, 5'd20, 0, 0, 0, 0, 0);
        step(1, 1, 5'd21, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'(22 + i), 0, 1, 1, 0, 0);
        end
        step(1, 0, 5'd0, 0, 1, 1, 1, 0);
        step(1, 0, 5'd0, 0, 1, 1, 1, 0);

        // Enough correctly predicted branches to saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 5'(i), 0, 0, 0, 0, 0);
            step(1, 0, 5'd0, 1, 0, 0, 0, 0);
            step(1, 0, 5'd0, 0, 1, 1, 1, 0);
        end
        // Mispredicts to saturate the small mispredict counter
        for (int i = 0; i < 18; i++) begin
            step(1, 1, 5'(i), 0, 0, 0, 0, 0);
            step(1, 0, 5'd0, 0, 0, 0, 0, 0);
            step(1, 0, 5'd0, 0, 1, 1, 1, 0);
        end

        // Random traffic with a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                apply_reset();
            end
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every fetched instruction from the point its branch prediction is read out of the branch history table until execute resolves it.
- Drives the BHT read address; pairs each fetch PC with the registered prediction returned one cycle later; queues {pc_low, prediction} in program order.
- At resolution it generates the BHT update fields (write address, was_taken, jumped, branch), detects mispredictions, flushes wrong-path entries, and keeps saturating performance counters.

Parameters:
- LOWER, 5, PC index bits; must match the BHT.
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 = stall, all state holds
- fetch_valid  in  1  instruction fetched this cycle
- fetch_pc  in  LOWER  low PC bits of the fetched instruction
- fetch_ready  out  1  queue can accept a fetch this cycle
- bht_read_addr  out  LOWER  combinational copy of fetch_pc
- prediction  in  1  BHT output; valid the cycle after the fetch
- resolve_valid  in  1  execute resolves the oldest queued instruction
- resolve_branch  in  1  resolved instruction is a conditional branch
- resolve_taken  in  1  branch outcome
- resolve_jump  in  1  resolved instruction is an unconditional jump
- bht_write_addr  out  LOWER  BHT update index (registered)
- bht_was_taken  out  1  registered: resolve_branch & resolve_taken
- bht_jumped  out  1  registered: resolve_jump
- bht_branch  out  1  registered: resolve_branch
- mispredict  out  1  registered one-cycle pulse
- queue_empty  out  1  no valid entries and no pending capture
- branch_count  out  CNT_W  resolved conditional branches
- mispredict_count  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, arst_n=0): all of the following are 0:
  - pointers, count, pending-capture register p_valid/p_pc
  - bht_write_addr, bht_was_taken, bht_jumped, bht_branch
  - mispredict, both counters
  - queue_empty=1, fetch_ready=1.
  - Reset asserted mid-operation discards all entries immediately.
- en=0: every register holds, outputs included. fetch_valid and resolve_valid are ignored.
- fetch_ready = (count + p_valid) < DEPTH. Combinational; accounts for the capture still in flight.
- Fetch accept (en & fetch_valid & fetch_ready): p_pc<=fetch_pc, p_valid<=1. A fetch with fetch_ready=0 is dropped; upstream must hold it.
- Capture: in the cycle after accept (en & p_valid), push {p_pc, prediction} at the tail. p_valid clears unless a new fetch is accepted in the same cycle.
- Latency: fetch to queue entry is 1 cycle. An entry can be resolved no earlier than the cycle after it is pushed.
- Resolve (en & resolve_valid & count!=0): pop the head. Next edge:
  - bht_write_addr<=head_pc
  - bht_was_taken, bht_jumped, bht_branch set per their port definitions
  - mispredict<=resolve_branch & (resolve_taken != head_pred)
- No-resolve cycle (en=1): bht_was_taken, bht_jumped, bht_branch and mispredict go to 0; bht_write_addr holds. A stray BHT increment is therefore impossible.
- Resolve with count==0: ignored, treated as a no-resolve cycle.
- Jumps never set mispredict. The jump target is handled elsewhere.
- Mispredict flush, in the same cycle as the resolving pop:
  - count<=0, head=tail=0, p_valid<=0.
  - A fetch accepted in that cycle is discarded.
  - fetch_ready stays combinational off the pre-flush state.
- Simultaneous push and pop without mispredict: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Counters: branch_count +1 per popped entry with resolve_branch. mispredict_count +1 per mispredict. Both saturate at all-ones.
- queue_empty = (count==0) & ~p_valid.

Test Plan:
- Reset → after arst_n deasserts: queue_empty=1, fetch_ready=1, all outputs 0.
- Fetch pc=3, prediction=1 next cycle; two cycles later resolve branch taken → bht_write_addr=3, was_taken=1, mispredict=0, branch_count=1.
- Fetch pc=7, prediction=0; resolve branch taken → mispredict=1 for exactly one cycle, mispredict_count=1. Two younger entries queued behind it are flushed: queue_empty=1 the cycle after.
- Fetch on 4 consecutive cycles (DEPTH=4) with no resolves → fetch_ready=0 after the 4th accept; a 5th fetch_valid is dropped. Resolve once → fetch_ready=1. Head pcs pop in order 0,1,2,3 across pointer wrap.
- resolve_jump=1 on entry pc=12 → bht_jumped=1, bht_write_addr=12, mispredict=0, branch_count unchanged. resolve_valid with empty queue → all update outputs 0.
- Hold en=0 for 3 cycles mid-stream with fetch_valid and resolve_valid asserted → no state or output change. Preload branch_count to all-ones via 2^CNT_W branches (CNT_W=4 build) → count stays 15.
